// File: rtl/lc3_mem_pkg.sv
// Shared constants, FSM state type and address decode for the LC-3 memory responder.
package lc3_mem_pkg;

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;

    localparam int READY_BIT   = 15;
    localparam int OVERRUN_BIT = 14;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DONE    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        TGT_RAM  = 3'd0,
        TGT_KBSR = 3'd1,
        TGT_KBDR = 3'd2,
        TGT_DSR  = 3'd3,
        TGT_DDR  = 3'd4
    } target_t;

    // Anything outside the four device words falls through to the aliased RAM.
    function automatic target_t decode_target(input logic [15:0] addr);
        case (addr)
            KBSR_ADDR: return TGT_KBSR;
            KBDR_ADDR: return TGT_KBDR;
            DSR_ADDR:  return TGT_DSR;
            DDR_ADDR:  return TGT_DDR;
            default:   return TGT_RAM;
        endcase
    endfunction

endpackage

// File: rtl/lc3_mem_responder_if.sv
// MAR/MDR request bus between the LC-3 memory-stage initiator and the responder.
interface lc3_mem_responder_if;
    logic [15:0] MAROut;
    logic [15:0] MDROut;
    logic        memEn;
    logic        memWE;
    logic [15:0] memOut;
    logic        R;

    modport master (
        output MAROut, MDROut, memEn, memWE,
        input  memOut, R
    );

    modport slave (
        input  MAROut, MDROut, memEn, memWE,
        output memOut, R
    );
endinterface

// File: rtl/lc3_mem_responder_ram.sv
// Synchronous single-port word RAM; a read during a write returns the old contents.
module mem_resp_ram #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [15:0]           wdata,
    output logic [15:0]           rdata
);
    logic [15:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        rdata <= mem[addr];
        if (we) begin
            mem[addr] <= wdata;
        end
    end
endmodule

// File: rtl/lc3_mem_responder.sv
// LC-3 memory-stage responder: one outstanding request, programmable wait states,
// word RAM plus keyboard/display device registers, one-cycle R completion pulse.
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_LOG2  = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    lc3_mem_responder_if.slave        bus,
    input  logic [7:0]                kbdData,
    input  logic                      kbdValid,
    output logic [7:0]                ddrData,
    output logic                      ddrValid,
    input  logic                      dispReady
);
    localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [15:0]           addr_p0;
    logic [15:0]           wdata_p0;
    logic                  we_p0;
    logic                  r_q;
    logic [15:0]           memout_q;

    logic                  kbd_ready;
    logic                  kbd_overrun;
    logic [7:0]            kbd_char;
    logic [7:0]            ddr_data_q;
    logic                  ddr_valid_q;

    target_t               tgt;
    logic                  done_rd;
    logic                  done_wr;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic                  ram_we;
    logic [15:0]           ram_q;
    logic [15:0]           rd_val;

    assign tgt     = decode_target(addr_p0);
    assign done_rd = (state == DONE) && !we_p0;
    assign done_wr = (state == DONE) && we_p0;

    // In IDLE the live address feeds the RAM so a zero-wait read has data in DONE.
    assign ram_addr = (state == IDLE) ? bus.MAROut[DEPTH_LOG2-1:0]
                                      : addr_p0[DEPTH_LOG2-1:0];
    assign ram_we   = done_wr && (tgt == TGT_RAM) && !reset;

    mem_resp_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_p0),
        .rdata (ram_q)
    );

    always_comb begin
        rd_val = '0;
        case (tgt)
            TGT_RAM:  rd_val = ram_q;
            TGT_KBSR: begin
                rd_val[READY_BIT]   = kbd_ready;
                rd_val[OVERRUN_BIT] = kbd_overrun;
            end
            TGT_KBDR: rd_val = {8'h00, kbd_char};
            TGT_DSR:  rd_val[READY_BIT] = ~ddr_valid_q;
            default:  rd_val = '0;
        endcase
    end

    // Read data is presented from registered sources during DONE so it lines up
    // with R; memout_q then holds it until the next read completes.
    assign bus.memOut = done_rd ? rd_val : memout_q;
    assign bus.R      = r_q;
    assign ddrData    = ddr_data_q;
    assign ddrValid   = ddr_valid_q;

    // ---- request FSM / wait counter ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            we_p0    <= 1'b0;
            r_q      <= 1'b0;
            memout_q <= '0;
        end else begin
            r_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.memEn) begin
                        addr_p0  <= bus.MAROut;
                        wdata_p0 <= bus.MDROut;
                        we_p0    <= bus.memWE;
                        cnt      <= CNT_W'(WAIT_CYCLES);
                        if (WAIT_CYCLES == 0) begin
                            state <= DONE;
                            r_q   <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                        r_q   <= 1'b1;
                    end
                end
                DONE: begin
                    if (!we_p0) begin
                        memout_q <= rd_val;
                    end
                    state <= RELEASE;
                end
                RELEASE: begin
                    if (!bus.memEn) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---- keyboard and display device registers ----
    always_ff @(posedge clk) begin
        if (reset) begin
            kbd_ready   <= 1'b0;
            kbd_overrun <= 1'b0;
            kbd_char    <= '0;
            ddr_data_q  <= '0;
            ddr_valid_q <= 1'b0;
        end else begin
            // A KBDR read frees the buffer, so a same-cycle strobe is captured, not dropped.
            if (done_rd && (tgt == TGT_KBDR)) begin
                kbd_overrun <= 1'b0;
                kbd_ready   <= kbdValid;
                if (kbdValid) begin
                    kbd_char <= kbdData;
                end
            end else if (kbdValid) begin
                if (kbd_ready) begin
                    kbd_overrun <= 1'b1;
                end else begin
                    kbd_char  <= kbdData;
                    kbd_ready <= 1'b1;
                end
            end

            if (ddr_valid_q && dispReady) begin
                ddr_valid_q <= 1'b0;
            end
            if (done_wr && (tgt == TGT_DDR) && !ddr_valid_q) begin
                ddr_data_q  <= wdata_p0[7:0];
                ddr_valid_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed bench for lc3_mem_responder: a 2-wait-state instance and a zero-wait instance.
module tb_lc3_mem_responder;
    import lc3_mem_pkg::*;

    logic clk;
    logic reset;
    logic [7:0] kbd_data, kbd0_data;
    logic kbd_valid, kbd0_valid;
    logic [7:0] ddr_data, ddr0_data;
    logic ddr_valid, ddr0_valid;
    logic disp_ready, disp0_ready;

    int total;
    int bad;
    logic [15:0] rd;
    int lat;
    int ex;
    int rcount;

    lc3_mem_responder_if bus2 ();
    lc3_mem_responder_if bus0 ();

    lc3_mem_responder #(.WAIT_CYCLES(2), .DEPTH_LOG2(10)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus2.slave),
        .kbdData   (kbd_data),
        .kbdValid  (kbd_valid),
        .ddrData   (ddr_data),
        .ddrValid  (ddr_valid),
        .dispReady (disp_ready)
    );

    lc3_mem_responder #(.WAIT_CYCLES(0), .DEPTH_LOG2(10)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus0.slave),
        .kbdData   (kbd0_data),
        .kbdValid  (kbd0_valid),
        .ddrData   (ddr0_data),
        .ddrValid  (ddr0_valid),
        .dispReady (disp0_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic en, input logic we,
                         input logic [15:0] a, input logic [15:0] d);
        if (sel) begin
            bus0.memEn = en; bus0.memWE = we; bus0.MAROut = a; bus0.MDROut = d;
        end else begin
            bus2.memEn = en; bus2.memWE = we; bus2.MAROut = a; bus2.MDROut = d;
        end
    endtask

    // Call just after a rising edge with the DUT idle; returns just after a rising edge.
    task automatic access(input bit sel, input logic we, input logic [15:0] a,
                          input logic [15:0] d, output logic [15:0] rdata,
                          output int latency, output int extra);
        bit got;
        got = 1'b0;
        latency = 0;
        extra = 0;
        rdata = '0;
        drive(sel, 1'b1, we, a, d);
        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            latency++;
            if ((sel ? bus0.R : bus2.R) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) latency = 99;
        rdata = sel ? bus0.memOut : bus2.memOut;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if ((sel ? bus0.R : bus2.R) !== 1'b0) extra++;
        end
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(posedge clk);
        #1;
    endtask

    task automatic kbd_push(input logic [7:0] c);
        kbd_data  = c;
        kbd_valid = 1'b1;
        @(posedge clk);
        #1;
        kbd_valid = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        kbd_data = '0; kbd_valid = 1'b0; disp_ready = 1'b0;
        kbd0_data = '0; kbd0_valid = 1'b0; disp0_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_R", 32'(bus2.R), 32'h0);
        check("rst_memOut", 32'(bus2.memOut), 32'h0);
        check("rst_ddrValid", 32'(ddr_valid), 32'h0);
        check("rst_ddrData", 32'(ddr_data), 32'h0);
        check("rst_state", 32'(dut2.state), 32'(IDLE));
        check("rst0_ddrValid", 32'(ddr0_valid), 32'h0);
        check("rst0_ddrData", 32'(ddr0_data), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Write then read with two wait states
        access(1'b0, 1'b1, 16'h0040, 16'h1234, rd, lat, ex);
        check("w2_wr_lat", 32'(lat), 32'd3);
        check("w2_wr_extraR", 32'(ex), 32'd0);
        access(1'b0, 1'b0, 16'h0040, 16'h0000, rd, lat, ex);
        check("w2_rd_lat", 32'(lat), 32'd3);
        check("w2_rd_data", 32'(rd), 32'h1234);
        check("w2_rd_extraR", 32'(ex), 32'd0);
        check("w2_memOut_hold", 32'(bus2.memOut), 32'h1234);

        // Zero wait states, address aliasing
        access(1'b1, 1'b1, 16'h0005, 16'hBEEF, rd, lat, ex);
        check("w0_wr_lat", 32'(lat), 32'd1);
        access(1'b1, 1'b0, 16'h0405, 16'h0000, rd, lat, ex);
        check("w0_rd_lat", 32'(lat), 32'd1);
        check("w0_alias_data", 32'(rd), 32'hBEEF);
        check("w0_extraR", 32'(ex), 32'd0);

        // Keyboard: single char
        kbd_push(8'h41);
        access(1'b0, 1'b0, 16'hFE00, 16'h0000, rd, lat, ex);
        check("kbsr_ready", 32'(rd), 32'h8000);
        access(1'b0, 1'b0, 16'hFE02, 16'h0000, rd, lat, ex);
        check("kbdr_char", 32'(rd), 32'h0041);
        access(1'b0, 1'b0, 16'hFE00, 16'h0000, rd, lat, ex);
        check("kbsr_cleared", 32'(rd), 32'h0000);

        // Keyboard: overrun
        kbd_push(8'h41);
        kbd_push(8'h42);
        access(1'b0, 1'b0, 16'hFE00, 16'h0000, rd, lat, ex);
        check("kbsr_overrun", 32'(rd), 32'hC000);
        access(1'b0, 1'b0, 16'hFE02, 16'h0000, rd, lat, ex);
        check("kbdr_first_kept", 32'(rd), 32'h0041);
        access(1'b0, 1'b0, 16'hFE00, 16'h0000, rd, lat, ex);
        check("kbsr_after_ovr", 32'(rd), 32'h0000);

        // Display
        access(1'b0, 1'b0, 16'hFE04, 16'h0000, rd, lat, ex);
        check("dsr_idle", 32'(rd), 32'h8000);
        access(1'b0, 1'b1, 16'hFE06, 16'h0058, rd, lat, ex);
        check("ddr_wr_lat", 32'(lat), 32'd3);
        check("ddr_valid_set", 32'(ddr_valid), 32'h1);
        check("ddr_data", 32'(ddr_data), 32'h58);
        access(1'b0, 1'b0, 16'hFE04, 16'h0000, rd, lat, ex);
        check("dsr_busy", 32'(rd), 32'h0000);
        access(1'b0, 1'b1, 16'hFE06, 16'h0059, rd, lat, ex);
        check("ddr_drop_lat", 32'(lat), 32'd3);
        check("ddr_drop_data", 32'(ddr_data), 32'h58);
        disp_ready = 1'b1;
        @(negedge clk);
        check("ddr_valid_before", 32'(ddr_valid), 32'h1);
        @(negedge clk);
        check("ddr_valid_clear", 32'(ddr_valid), 32'h0);
        @(posedge clk);
        #1;
        disp_ready = 1'b0;
        access(1'b0, 1'b0, 16'hFE04, 16'h0000, rd, lat, ex);
        check("dsr_ready_again", 32'(rd), 32'h8000);

        // Reset during WAIT aborts a write
        access(1'b0, 1'b1, 16'h0010, 16'h5A5A, rd, lat, ex);
        drive(1'b0, 1'b1, 1'b1, 16'h0010, 16'hDEAD);
        @(posedge clk);
        #1;
        check("abort_in_wait", 32'(dut2.state), 32'(WAIT));
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        rcount = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus2.R !== 1'b0) rcount++;
        end
        check("abort_noR", 32'(rcount), 32'd0);
        check("abort_state", 32'(dut2.state), 32'(IDLE));
        @(posedge clk);
        #1;
        access(1'b0, 1'b0, 16'h0010, 16'h0000, rd, lat, ex);
        check("abort_ram_kept", 32'(rd), 32'h5A5A);

        // Ignored accesses still complete
        access(1'b0, 1'b1, 16'hFE00, 16'hFFFF, rd, lat, ex);
        check("kbsr_wr_R", 32'(lat), 32'd3);
        access(1'b0, 1'b0, 16'hFE00, 16'h0000, rd, lat, ex);
        check("kbsr_rd_R", 32'(lat), 32'd3);
        check("kbsr_unchanged", 32'(rd), 32'h0000);
        access(1'b0, 1'b0, 16'hFE06, 16'h0000, rd, lat, ex);
        check("ddr_read_zero", 32'(rd), 32'h0000);
        check("ddr_read_R", 32'(lat), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
